prbs_checker: RTL

//  Serial pseudorandom-sequence checker: the receive end of the team's LFSR generator.

---
 rtl/prbs_checker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-seeds from the received stream, verifies the LFSR
// recurrence, declares lock, then flags and counts bit errors against a free-running reference.
module prbs_checker #(
    parameter int unsigned      WIDTH         = 4,
    parameter logic [WIDTH-1:0] TAPS          = 4'b1010,
    parameter int unsigned      LOCK_THRESH   = 8,
    parameter int unsigned      UNLOCK_THRESH = 4,
    parameter int unsigned      CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic             data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned SEED_W  = $clog2(WIDTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int unsigned RUN_W   = $clog2(UNLOCK_THRESH + 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]    err_cnt_d;
    logic                pred_c;
    logic                in_bit_c;
    logic                err_c;

    assign pred_c = ^(shreg_q & TAPS);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter and shift-register update
    always_comb begin
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        run_cnt_d   = run_cnt_q;
        in_bit_c    = data_i;
        err_c       = 1'b0;
        shreg_d     = shreg_q;

        if (valid_i) begin
            case (state_q)
                SEED: begin
                    if (seed_cnt_q == SEED_W'(WIDTH - 1)) begin
                        state_d     = VERIFY;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end
                VERIFY: begin
                    // An all-zero register predicts the all-zero stream, which is never a valid lock.
                    if ((data_i == pred_c) && (shreg_q != '0)) begin
                        if (match_cnt_q == MATCH_W'(LOCK_THRESH - 1)) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            run_cnt_d   = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        state_d     = SEED;
                        seed_cnt_d  = SEED_W'(1);
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Reference free-runs so a single line error is counted exactly once.
                    in_bit_c = pred_c;
                    if (data_i != pred_c) begin
                        err_c = 1'b1;
                        if (run_cnt_q == RUN_W'(UNLOCK_THRESH - 1)) begin
                            state_d     = SEED;
                            seed_cnt_d  = '0;
                            match_cnt_d = '0;
                            run_cnt_d   = '0;
                        end else begin
                            run_cnt_d = run_cnt_q + RUN_W'(1);
                        end
                    end else begin
                        run_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SEED;
                end
            endcase
            shreg_d = {shreg_q[WIDTH-2:0], in_bit_c};
        end
    end

    // Saturating error counter; clear and a coincident error both apply
    always_comb begin
        err_cnt_d = err_cnt_o;
        if (clear_i) begin
            err_cnt_d = CNT_W'(err_c);
        end else if (err_c && (err_cnt_o != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_o + CNT_W'(1);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q     <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            run_cnt_q   <= '0;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            shreg_q     <= shreg_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            run_cnt_q   <= run_cnt_d;
            locked_o    <= (state_d == LOCKED);
            err_o       <= err_c;
            err_cnt_o   <= err_cnt_d;
        end
    end

endmodule
